wshb_mire: RTL and testbench
============================

Name: wshb_mire

Overview:
- Wishbone master in the sys_clk domain that continuously writes a test-pattern frame (a grid) into the SDRAM framebuffer.
- The vga stage reads the framebuffer back and displays it.
- The block releases the bus periodically so the SDRAM arbiter can serve the vga reader.
- It replaces the constant tie-offs on the SDRAM-side master bus.

Parameters:
HDISP, 800, pixels per line
VDISP, 480, lines per frame
BURST, 64, consecutive completed writes before a mandatory bus release
GRID, 16, grid pitch in pixels; power of 2
COLOR_FG, 32'h00FFFFFF, grid-line colour {8'h00,R,G,B}
COLOR_BG, 32'h00000000, background colour

Ports:
sys_clk  in  1  system clock (100 MHz)
sys_rst  in  1  asynchronous reset, active high
enable  in  1  pattern generation enable
wshb_cyc  out  1  Wishbone cycle
wshb_stb  out  1  Wishbone strobe
wshb_we  out  1  write enable; constant 1
wshb_adr  out  32  byte address
wshb_dat_ms  out  32  write data
wshb_sel  out  4  byte select; constant 4'hF
wshb_cti  out  3  constant 3'b000 (classic cycle)
wshb_bte  out  2  constant 2'b00
wshb_ack  in  1  slave acknowledge
wshb_err  in  1  slave error
wshb_rty  in  1  slave retry
frame_done  out  1  one-cycle pulse on completion of the last pixel of a frame

Behaviour:
- Reset: sys_rst asynchronous and active high; takes effect immediately without a clock edge.
- Reset values: state=IDLE, x=0, y=0, adr=0, burst count=0, cyc=stb=0, frame_done=0.
- States and transitions:
  - IDLE: cyc=stb=0. Goes to WRITE on the first edge with enable=1.
  - WRITE: cyc=stb=1. adr/dat_ms are held stable until a termination (ack, err or rty) is sampled.
  - PAUSE: cyc=stb=0 for exactly one cycle. Then goes to WRITE if enable=1, else IDLE.
- Write data:
  - dat_ms = COLOR_FG if x mod GRID == 0 or y mod GRID == 0; otherwise COLOR_BG.
  - Registered together with adr; no combinational path from inputs to outputs.
- Address:
  - adr = 4*(y*HDISP + x).
  - Maintained by incrementing the registered address by 4 per completed write; no multiplier.
- Completion (ack or err sampled high in WRITE):
  - x increments.
  - At x = HDISP-1, x goes to 0 and y increments.
  - At (HDISP-1, VDISP-1): x=y=0, adr=0, and frame_done=1 for the following cycle.
  - err is treated as completion: the pixel is dropped, with no retry.
- Retry (rty high, ack/err low): go to PAUSE; the same x, y, adr and dat_ms are reissued. Burst count is unchanged.
- ack and err both high in the same cycle: a single completion.
- Burst release:
  - The burst counter counts completions.
  - When the BURST-th completion is sampled, go to PAUSE and clear the counter.
  - The counter is independent of the frame wrap and continues across it.
- enable low while in WRITE:
  - The current transfer is held (stb stays high) until it terminates; a transfer is never abandoned.
  - Then go to IDLE with cyc=0. Position and address are retained.
  - On re-enable, writing resumes at the next pixel.
- enable low in IDLE: stay in IDLE.
- Latency:
  - First stb: one cycle after the first edge with enable=1 and reset released.
  - Back-to-back writes: stb stays high across an ack, with the next address presented on the cycle after the ack.
- Widths:
  - x width is $clog2(HDISP).
  - y width is $clog2(VDISP).
  - adr has 32 bits; upper bits are zero.

Test Plan:
- Frame write: HDISP=32, VDISP=20, GRID=16, BURST=64, ack tied 1, enable=1 -> the first write is adr 0, dat 32'h00FFFFFF. All 32 writes of row 0 are FFFFFF. adr 128 (x=0,y=1) is FFFFFF; adr 132 (x=1,y=1) is 0; adr 4*(16*32+5) is FFFFFF.
- Slow slave: ack asserted 3 cycles after stb -> adr, dat_ms, cyc and stb stay constant for all 3 wait cycles. The next address appears on the cycle after ack.
- Burst release: after the 64th ack (adr 252), cyc=0 for exactly one cycle. The next stb is at adr 256. The counter wraps correctly over 640 writes.
- Frame wrap: HDISP=32, VDISP=20 -> after the ack of adr 2556, frame_done=1 for one cycle, the next adr is 0, and x=y=0.
- Retry/error: rty on adr 40 -> one idle cycle, then adr 40 is reissued with the same data. err on adr 44 -> the next write is adr 48.
- Enable/reset:
  - enable dropped during a waited transfer at adr 80 -> stb is held until ack, then cyc=0. Re-enable -> the next write is adr 84.
  - sys_rst asserted mid-transfer -> cyc=stb=0 asynchronously, before the next edge. After release, writing restarts at adr 0.

Source files
------------

// File: rtl/wshb_mire.sv
`default_nettype none
// ============================================================================
// Module   : wshb_mire
// Brief    : Wishbone master that keeps writing a grid test pattern into the
//            SDRAM framebuffer, yielding the bus after every burst.
// Revision : 1.0 - initial release
// ============================================================================
module wshb_mire #(
    parameter int          HDISP    = 800,
    parameter int          VDISP    = 480,
    parameter int          BURST    = 64,
    parameter int          GRID     = 16,
    parameter logic [31:0] COLOR_FG = 32'h00FFFFFF,
    parameter logic [31:0] COLOR_BG = 32'h00000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic        wshb_ack,
    input  logic        wshb_err,
    input  logic        wshb_rty,
    output logic        frame_done
);

    localparam int c_XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int c_YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int c_BW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [c_XW-1:0] c_X_LAST     = c_XW'(HDISP - 1);
    localparam logic [c_YW-1:0] c_Y_LAST     = c_YW'(VDISP - 1);
    localparam logic [c_BW-1:0] c_BURST_LAST = c_BW'(BURST - 1);
    localparam logic [31:0]     c_GRID_MASK  = 32'(GRID - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_XW-1:0]   r_x;
    logic [c_YW-1:0]   r_y;
    logic [31:0]       r_adr;
    logic [31:0]       r_dat;
    logic [c_BW-1:0]   r_burst;
    logic              r_cyc;
    logic              r_stb;
    logic              r_frame_done;

    logic              w_x_last;
    logic              w_y_last;
    logic              w_frame_last;
    logic              w_burst_last;
    logic              w_done;
    logic              w_retry;
    logic [c_XW-1:0]   w_x_next;
    logic [c_YW-1:0]   w_y_next;
    logic [31:0]       w_adr_next;

    // GRID is a power of two, so the modulo reduces to a mask of the low bits.
    function automatic logic [31:0] f_pattern(input logic [c_XW-1:0] px,
                                              input logic [c_YW-1:0] py);
        logic on_line;
        on_line = ((32'(px) & c_GRID_MASK) == 32'd0) ||
                  ((32'(py) & c_GRID_MASK) == 32'd0);
        return on_line ? COLOR_FG : COLOR_BG;
    endfunction

    always_comb begin
        w_x_last     = (r_x == c_X_LAST);
        w_y_last     = (r_y == c_Y_LAST);
        w_frame_last = w_x_last && w_y_last;
        w_x_next     = w_x_last ? '0 : r_x + 1'b1;
        if (!w_x_last)
            w_y_next = r_y;
        else if (w_y_last)
            w_y_next = '0;
        else
            w_y_next = r_y + 1'b1;
        w_adr_next   = w_frame_last ? 32'd0 : r_adr + 32'd4;
        w_burst_last = (r_burst == c_BURST_LAST);
        w_done       = wshb_ack | wshb_err;
        w_retry      = wshb_rty & ~w_done;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_adr        <= 32'd0;
            r_dat        <= f_pattern('0, '0);
            r_burst      <= '0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_WRITE;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                    end
                end
                S_WRITE: begin
                    // err counts as completion: the pixel is simply dropped.
                    if (w_done) begin
                        r_x          <= w_x_next;
                        r_y          <= w_y_next;
                        r_adr        <= w_adr_next;
                        r_dat        <= f_pattern(w_x_next, w_y_next);
                        r_frame_done <= w_frame_last;
                        if (w_burst_last) begin
                            r_burst <= '0;
                            r_state <= S_PAUSE;
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                        end else begin
                            r_burst <= r_burst + 1'b1;
                            if (!enable) begin
                                r_state <= S_IDLE;
                                r_cyc   <= 1'b0;
                                r_stb   <= 1'b0;
                            end
                        end
                    end else if (w_retry) begin
                        r_state <= S_PAUSE;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (enable) begin
                        r_state <= S_WRITE;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                end
            endcase
        end
    end

    assign wshb_cyc    = r_cyc;
    assign wshb_stb    = r_stb;
    assign wshb_we     = 1'b1;
    assign wshb_adr    = r_adr;
    assign wshb_dat_ms = r_dat;
    assign wshb_sel    = 4'hF;
    assign wshb_cti    = 3'b000;
    assign wshb_bte    = 2'b00;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_wshb_mire.sv
`default_nettype none
// ============================================================================
// Module   : tb_wshb_mire
// Brief    : Self-checking bench for wshb_mire on a 32x20 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wshb_mire;

    localparam int          HDISP = 32;
    localparam int          VDISP = 20;
    localparam int          BURST = 64;
    localparam int          GRID  = 16;
    localparam logic [31:0] FG    = 32'h00FFFFFF;
    localparam logic [31:0] BG    = 32'h00000000;
    localparam int          c_FRAME_BYTES = 4 * HDISP * VDISP;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        enable  = 1'b0;
    logic        wshb_cyc, wshb_stb, wshb_we;
    logic [31:0] wshb_adr, wshb_dat_ms;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic        wshb_ack = 1'b0;
    logic        wshb_err = 1'b0;
    logic        wshb_rty = 1'b0;
    logic        frame_done;

    wshb_mire #(
        .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .GRID(GRID),
        .COLOR_FG(FG), .COLOR_BG(BG)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
        .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_we(wshb_we),
        .wshb_adr(wshb_adr), .wshb_dat_ms(wshb_dat_ms), .wshb_sel(wshb_sel),
        .wshb_cti(wshb_cti), .wshb_bte(wshb_bte), .wshb_ack(wshb_ack),
        .wshb_err(wshb_err), .wshb_rty(wshb_rty), .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    int          mx = 0, my = 0;
    int          total = 0, bad = 0;
    int          completions = 0, ack_delay = 0, wait_cnt = 0;
    logic [31:0] rty_at = '1, err_at = '1;
    logic [31:0] hold_adr = '0, hold_dat = '0;
    logic [31:0] prev_adr = '0, prev_dat = '0;
    logic        done = 1'b0;

    // Slave responder and scoreboard; expected writes follow raster order.
    task automatic slave_monitor();
        exp_t e;
        forever begin
            @(negedge sys_clk);
            wshb_ack = 1'b0; wshb_err = 1'b0; wshb_rty = 1'b0;
            while (sb.size() < 4) begin
                e.adr = 32'(4 * (my * HDISP + mx));
                e.dat = ((mx % GRID) == 0 || (my % GRID) == 0) ? FG : BG;
                sb.push_back(e);
                if (mx == HDISP - 1) begin
                    mx = 0;
                    my = (my == VDISP - 1) ? 0 : my + 1;
                end else begin
                    mx++;
                end
            end
            if (!sys_rst && wshb_cyc && wshb_stb) begin
                if (wait_cnt > 0) begin
                    total++;
                    if (wshb_adr !== hold_adr || wshb_dat_ms !== hold_dat) begin
                        bad++;
                        $display("FAIL hold: adr=%h dat=%h, required adr=%h dat=%h",
                                 wshb_adr, wshb_dat_ms, hold_adr, hold_dat);
                    end
                end else begin
                    hold_adr = wshb_adr;
                    hold_dat = wshb_dat_ms;
                end
                if (wait_cnt >= ack_delay) begin
                    wait_cnt = 0;
                    e = sb[0];
                    total++;
                    if (wshb_adr !== e.adr || wshb_dat_ms !== e.dat) begin
                        bad++;
                        $display("FAIL scoreboard: adr=%h dat=%h, required adr=%h dat=%h",
                                 wshb_adr, wshb_dat_ms, e.adr, e.dat);
                    end
                    if (wshb_adr == rty_at) begin
                        wshb_rty = 1'b1;
                        rty_at   = '1;
                    end else begin
                        if (wshb_adr == err_at) begin
                            wshb_err = 1'b1;
                            err_at   = '1;
                        end else begin
                            wshb_ack = 1'b1;
                        end
                        e = sb.pop_front();
                        completions++;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    endtask

    task automatic tick();
        prev_adr = wshb_adr;
        prev_dat = wshb_dat_ms;
        @(posedge sys_clk);
        #2;
        done = wshb_ack || wshb_err;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0; enable = 1'b0;
        #3 sys_rst = 1'b1;
        #1;
        total++; if ({wshb_cyc, wshb_stb} !== 2'b00) begin bad++; $display("FAIL reset_cyc_stb: got %b required 00", {wshb_cyc, wshb_stb}); end
        total++; if (wshb_adr !== 32'd0) begin bad++; $display("FAIL reset_adr: got %h required 0", wshb_adr); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        total++;
        if ({wshb_we, wshb_sel, wshb_cti, wshb_bte} !== {1'b1, 4'hF, 3'b000, 2'b00}) begin
            bad++; $display("FAIL constants: we=%b sel=%h cti=%b bte=%b required 1 F 000 00",
                            wshb_we, wshb_sel, wshb_cti, wshb_bte);
        end
        tick(); tick();
        sys_rst = 1'b0;
        repeat (3) tick();
        total++; if (wshb_cyc !== 1'b0) begin bad++; $display("FAIL idle_hold: cyc=%b required 0", wshb_cyc); end
    endtask

    task automatic test_frame_write();
        bit f128 = 0, f132 = 0, f2068 = 0;
        int row0 = 0;
        ack_delay = 0;
        enable = 1'b1;
        #1;
        total++; if (wshb_stb !== 1'b0) begin bad++; $display("FAIL first_stb_early: stb=%b required 0", wshb_stb); end
        tick();
        total++; if ({wshb_cyc, wshb_stb} !== 2'b11) begin bad++; $display("FAIL first_stb: got %b required 11", {wshb_cyc, wshb_stb}); end
        total++; if (wshb_adr !== 32'd0) begin bad++; $display("FAIL first_adr: got %h required 0", wshb_adr); end
        total++; if (wshb_dat_ms !== FG) begin bad++; $display("FAIL first_dat: got %h required %h", wshb_dat_ms, FG); end
        for (int i = 0; i < 2000 && !(f128 && f132 && f2068); i++) begin
            tick();
            if (done && prev_adr < 32'd128) begin
                row0++; total++;
                if (prev_dat !== FG) begin bad++; $display("FAIL row0: adr=%h dat=%h required %h", prev_adr, prev_dat, FG); end
            end
            if (wshb_stb && wshb_adr == 32'd128 && !f128) begin
                f128 = 1; total++;
                if (wshb_dat_ms !== FG) begin bad++; $display("FAIL px_0_1: got %h required %h", wshb_dat_ms, FG); end
            end
            if (wshb_stb && wshb_adr == 32'd132 && !f132) begin
                f132 = 1; total++;
                if (wshb_dat_ms !== BG) begin bad++; $display("FAIL px_1_1: got %h required %h", wshb_dat_ms, BG); end
            end
            if (wshb_stb && wshb_adr == 32'(4 * (16 * 32 + 5)) && !f2068) begin
                f2068 = 1; total++;
                if (wshb_dat_ms !== FG) begin bad++; $display("FAIL px_5_16: got %h required %h", wshb_dat_ms, FG); end
            end
        end
        total++; if (row0 !== 32) begin bad++; $display("FAIL row0_count: got %0d required 32", row0); end
        total++; if (!(f128 && f132 && f2068)) begin bad++; $display("FAIL frame_write_timeout: seen %b required 111", {f128, f132, f2068}); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic [31:0] completed, nxt;
        for (int i = 0; i < 1500 && n < 640; i++) begin
            tick();
            if (done) begin
                n++;
                completed = prev_adr;
                nxt = (completed + 32'd4) % c_FRAME_BYTES;
                total++;
                if (frame_done !== (completed == 32'd2556)) begin
                    bad++; $display("FAIL frame_done_pulse: adr=%h got %b", completed, frame_done);
                end
                if (completions % BURST == 0) begin
                    total++;
                    if ({wshb_cyc, wshb_stb} !== 2'b00) begin bad++; $display("FAIL burst_release: adr=%h cyc/stb=%b required 00", completed, {wshb_cyc, wshb_stb}); end
                    tick();
                    total++;
                    if ({wshb_cyc, wshb_stb} !== 2'b11 || wshb_adr !== nxt) begin
                        bad++; $display("FAIL burst_resume: cyc/stb=%b adr=%h required 11 adr=%h", {wshb_cyc, wshb_stb}, wshb_adr, nxt);
                    end
                end else begin
                    total++;
                    if ({wshb_cyc, wshb_stb} !== 2'b11 || wshb_adr !== nxt) begin
                        bad++; $display("FAIL back_to_back: cyc/stb=%b adr=%h required 11 adr=%h", {wshb_cyc, wshb_stb}, wshb_adr, nxt);
                    end
                end
            end
        end
        total++; if (n !== 640) begin bad++; $display("FAIL burst_count: got %0d required 640", n); end
    endtask

    task automatic test_frame_wrap();
        bit hit = 0;
        for (int i = 0; i < 1500 && !hit; i++) begin
            tick();
            if (done && prev_adr == 32'd2556) begin
                hit = 1;
                total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL wrap_done: got %b required 1", frame_done); end
                total++; if (wshb_adr !== 32'd0 || wshb_dat_ms !== FG) begin bad++; $display("FAIL wrap_adr: adr=%h dat=%h required 0 %h", wshb_adr, wshb_dat_ms, FG); end
                tick();
                total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL wrap_pulse: got %b required 0", frame_done); end
                total++; if (wshb_adr !== 32'd0) begin bad++; $display("FAIL wrap_next: adr=%h required 0", wshb_adr); end
            end
        end
        total++; if (!hit) begin bad++; $display("FAIL wrap_timeout: got 0 required 1"); end
    endtask

    task automatic test_slow_slave();
        bit armed = 0, started = 0;
        int len = 0, measured = 0;
        logic [31:0] a = '0, d = '0;
        ack_delay = 3;
        for (int i = 0; i < 200 && measured < 5; i++) begin
            tick();
            if (done) begin
                if (started) begin
                    measured++;
                    total++; if (len !== 4) begin bad++; $display("FAIL slow_len: got %0d required 4", len); end
                    if (wshb_stb) begin
                        total++;
                        if (wshb_adr !== (a + 32'd4) % c_FRAME_BYTES) begin bad++; $display("FAIL slow_next: adr=%h required %h", wshb_adr, (a + 32'd4) % c_FRAME_BYTES); end
                    end
                end
                armed = 1; started = 0;
            end
            if (armed && !started && wshb_stb) begin
                started = 1; a = wshb_adr; d = wshb_dat_ms; len = 1;
            end else if (started && !done) begin
                len++; total++;
                if ({wshb_cyc, wshb_stb} !== 2'b11 || wshb_adr !== a || wshb_dat_ms !== d) begin
                    bad++; $display("FAIL slow_hold: cyc/stb=%b adr=%h dat=%h required 11 %h %h", {wshb_cyc, wshb_stb}, wshb_adr, wshb_dat_ms, a, d);
                end
            end
        end
        total++; if (measured !== 5) begin bad++; $display("FAIL slow_timeout: got %0d required 5", measured); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 50 && wshb_stb !== 1'b1; i++) tick();
        #1 sys_rst = 1'b1;
        #1;
        total++; if ({wshb_cyc, wshb_stb} !== 2'b00) begin bad++; $display("FAIL async_reset: cyc/stb=%b required 00", {wshb_cyc, wshb_stb}); end
        total++; if (wshb_adr !== 32'd0 || frame_done !== 1'b0) begin bad++; $display("FAIL async_reset_adr: adr=%h fd=%b required 0 0", wshb_adr, frame_done); end
        sb.delete(); mx = 0; my = 0; completions = 0; ack_delay = 0; wait_cnt = 0;
        tick(); tick();
        sys_rst = 1'b0;
        tick();
        total++;
        if (wshb_stb !== 1'b1 || wshb_adr !== 32'd0 || wshb_dat_ms !== FG) begin
            bad++; $display("FAIL restart: stb=%b adr=%h dat=%h required 1 0 %h", wshb_stb, wshb_adr, wshb_dat_ms, FG);
        end
    endtask

    task automatic test_retry_error();
        bit got_rty = 0, got_err = 0;
        rty_at = 32'd40; err_at = 32'd44;
        for (int i = 0; i < 200 && !got_err; i++) begin
            tick();
            if (wshb_rty && prev_adr == 32'd40) begin
                got_rty = 1;
                total++; if ({wshb_cyc, wshb_stb} !== 2'b00) begin bad++; $display("FAIL retry_idle: cyc/stb=%b required 00", {wshb_cyc, wshb_stb}); end
                tick();
                total++;
                if ({wshb_cyc, wshb_stb} !== 2'b11 || wshb_adr !== 32'd40 || wshb_dat_ms !== FG) begin
                    bad++; $display("FAIL retry_reissue: cyc/stb=%b adr=%h dat=%h required 11 28 %h", {wshb_cyc, wshb_stb}, wshb_adr, wshb_dat_ms, FG);
                end
            end else if (done && prev_adr == 32'd44) begin
                got_err = 1;
                total++;
                if (wshb_stb !== 1'b1 || wshb_adr !== 32'd48) begin bad++; $display("FAIL err_next: stb=%b adr=%h required 1 30", wshb_stb, wshb_adr); end
            end
        end
        total++; if (!(got_rty && got_err)) begin bad++; $display("FAIL retry_error_timeout: got %b required 11", {got_rty, got_err}); end
    endtask

    task automatic test_enable_drop();
        bit at80 = 0, fin = 0;
        ack_delay = 3;
        for (int i = 0; i < 300 && !at80; i++) begin
            tick();
            if (wshb_stb && wshb_adr == 32'd80) at80 = 1;
        end
        total++; if (!at80) begin bad++; $display("FAIL enable_timeout: got 0 required 1"); end
        enable = 1'b0;
        for (int i = 0; i < 20 && !fin; i++) begin
            tick();
            if (done) fin = 1;
            else begin
                total++;
                if ({wshb_cyc, wshb_stb} !== 2'b11 || wshb_adr !== 32'd80) begin
                    bad++; $display("FAIL enable_hold: cyc/stb=%b adr=%h required 11 50", {wshb_cyc, wshb_stb}, wshb_adr);
                end
            end
        end
        total++; if (!fin) begin bad++; $display("FAIL enable_ack_timeout: got 0 required 1"); end
        total++; if ({wshb_cyc, wshb_stb} !== 2'b00) begin bad++; $display("FAIL enable_stop: cyc/stb=%b required 00", {wshb_cyc, wshb_stb}); end
        repeat (4) tick();
        total++; if (wshb_cyc !== 1'b0 || wshb_adr !== 32'd84) begin bad++; $display("FAIL enable_idle: cyc=%b adr=%h required 0 54", wshb_cyc, wshb_adr); end
        ack_delay = 0;
        enable = 1'b1;
        tick();
        total++; if (wshb_stb !== 1'b1 || wshb_adr !== 32'd84) begin bad++; $display("FAIL enable_resume: stb=%b adr=%h required 1 54", wshb_stb, wshb_adr); end
    endtask

    task automatic test_burst_after_retry();
        bit hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            tick();
            if (done && prev_adr == 32'd248) begin
                total++; if (wshb_cyc !== 1'b1) begin bad++; $display("FAIL burst_early: cyc=%b required 1", wshb_cyc); end
            end
            if (done && prev_adr == 32'd252) begin
                hit = 1;
                total++; if (wshb_cyc !== 1'b0) begin bad++; $display("FAIL burst_252: cyc=%b required 0", wshb_cyc); end
                tick();
                total++; if (wshb_stb !== 1'b1 || wshb_adr !== 32'd256) begin bad++; $display("FAIL burst_256: stb=%b adr=%h required 1 100", wshb_stb, wshb_adr); end
            end
        end
        total++; if (!hit) begin bad++; $display("FAIL burst_252_timeout: got 0 required 1"); end
    endtask

    initial begin
        fork
            slave_monitor();
        join_none
        test_reset();
        test_frame_write();
        test_back_to_back();
        test_frame_wrap();
        test_slow_slave();
        test_reset_mid();
        test_retry_error();
        test_enable_drop();
        test_burst_after_retry();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
